// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher: decodes tagged UART frames into slot writes/reads, ping echo, coprocessor start and result readback
//   clk, reset                 clock, synchronous active-high reset
//   frame_valid, frame_data    RX frame strobe and frame {opcode, payload, tag}
//   tx_busy, tx_send, tx_frame UART TX handshake and response frame {opcode, payload, opcode}
//   cp_key, cp_text, cp_ld     slot0/slot1 contents and coprocessor start pulse
//   cp_done, cp_result         coprocessor completion and result
//   busy, result_valid         not IDLE / result latched since last start
//   err_count                  saturating error counter
module uart_cmd_dispatcher #(
    parameter int FRAME_BYTES = 18,
    parameter int NUM_SLOTS   = 4,
    parameter int CP_TIMEOUT  = 1024,
    localparam int PW = 8 * (FRAME_BYTES - 2),
    localparam int FW = 8 * FRAME_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_valid,
    input  logic [FW-1:0] frame_data,
    input  logic          tx_busy,
    output logic          tx_send,
    output logic [FW-1:0] tx_frame,
    output logic [PW-1:0] cp_key,
    output logic [PW-1:0] cp_text,
    output logic          cp_ld,
    input  logic          cp_done,
    input  logic [PW-1:0] cp_result,
    output logic          busy,
    output logic          result_valid,
    output logic [7:0]    err_count
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(CP_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, DECODE, RESP, WAIT_CP} state_t;

    state_t        state, state_next;
    logic [FW-1:0] frame_q;
    logic [PW-1:0] slots [NUM_SLOTS];
    logic [PW-1:0] result_q;
    logic [PW-1:0] resp_payload;
    logic [CW-1:0] cnt;
    logic          err;
    logic          wr_en;
    logic          load_tx;
    logic          slot_ok;
    logic [7:0]    opcode;
    logic [7:0]    tag;
    logic [PW-1:0] payload;
    logic [SW-1:0] idx;

    assign opcode  = frame_q[FW-1 -: 8];
    assign tag     = frame_q[7:0];
    assign payload = frame_q[FW-9:8];
    assign idx     = opcode[SW-1:0];
    assign slot_ok = int'(opcode[3:0]) < NUM_SLOTS;
    assign busy    = state != IDLE;
    assign cp_key  = slots[0];
    assign cp_text = slots[1];

    always_comb begin
        state_next   = state;
        err          = 1'b0;
        wr_en        = 1'b0;
        load_tx      = 1'b0;
        cp_ld        = 1'b0;
        resp_payload = payload;
        case (state)
            IDLE:    state_next = frame_valid ? DECODE : IDLE;
            DECODE: begin
                state_next = IDLE;
                if (tag != opcode)
                    err = 1'b1;
                else if (opcode[7:4] == 4'h5 && slot_ok)
                    wr_en = 1'b1;
                else if (opcode[7:4] == 4'h6 && slot_ok) begin
                    load_tx      = 1'b1;
                    resp_payload = slots[idx];
                end else if (opcode == 8'h41)
                    load_tx = 1'b1;
                else if (opcode == 8'h45)
                    cp_ld = 1'b1;
                else if (opcode == 8'h42 && result_valid) begin
                    load_tx      = 1'b1;
                    resp_payload = result_q;
                end else
                    err = 1'b1;
                if (load_tx)
                    state_next = RESP;
                if (cp_ld)
                    state_next = WAIT_CP;
            end
            RESP:    state_next = tx_busy ? RESP : IDLE;
            WAIT_CP: begin
                // done wins over a timeout landing on the same cycle
                if (cp_done)
                    state_next = IDLE;
                else if (cnt == CW'(CP_TIMEOUT - 1)) begin
                    err        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // a frame arriving outside IDLE is dropped; coincident errors count once
        if (frame_valid && state != IDLE)
            err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            frame_q      <= '0;
            tx_frame     <= '0;
            tx_send      <= 1'b0;
            result_q     <= '0;
            result_valid <= 1'b0;
            err_count    <= '0;
            cnt          <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)
                slots[i] <= '0;
        end else begin
            state   <= state_next;
            tx_send <= state == RESP && !tx_busy;
            cnt     <= state == WAIT_CP ? cnt + 1'b1 : '0;
            if (state == IDLE && frame_valid)
                frame_q <= frame_data;
            if (wr_en)
                slots[idx] <= payload;
            if (load_tx)
                tx_frame <= {opcode, resp_payload, opcode};
            if (cp_ld)
                result_valid <= 1'b0;
            else if (state == WAIT_CP && cp_done) begin
                result_q     <= cp_result;
                result_valid <= 1'b1;
            end
            if (err && err_count != 8'hFF)
                err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// tb_uart_cmd_dispatcher: directed self-checking bench for uart_cmd_dispatcher
module tb_uart_cmd_dispatcher;
    localparam int PW = 128;
    localparam int FW = 144;

    localparam logic [PW-1:0] K    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [PW-1:0] P    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [PW-1:0] PING = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [PW-1:0] X    = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [PW-1:0] R    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [PW-1:0] R2   = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [PW-1:0] R3   = 128'h1111222233334444555566667777888;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_valid = 1'b0;
    logic [FW-1:0] frame_data = '0;
    logic          tx_busy = 1'b0;
    logic          cp_done = 1'b0;
    logic [PW-1:0] cp_result = '0;
    logic          tx_send, cp_ld, busy, result_valid;
    logic [FW-1:0] tx_frame;
    logic [PW-1:0] cp_key, cp_text;
    logic [7:0]    err_count;
    int            total = 0;
    int            bad = 0;
    int            hits;

    always #5 clk = ~clk;

    uart_cmd_dispatcher #(.FRAME_BYTES(18), .NUM_SLOTS(4), .CP_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
        .tx_busy(tx_busy), .tx_send(tx_send), .tx_frame(tx_frame), .cp_key(cp_key),
        .cp_text(cp_text), .cp_ld(cp_ld), .cp_done(cp_done), .cp_result(cp_result),
        .busy(busy), .result_valid(result_valid), .err_count(err_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [7:0] tg, input logic [PW-1:0] pl);
        frame_data  = {op, pl, tg};
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_tx_send", tx_send, 0);
        chk("rst_cp_ld", cp_ld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_err", err_count, 0);
        chk("rst_tx_frame", tx_frame, 0);
        chk("rst_cp_key", cp_key, 0);

        send(8'h50, 8'h50, K);
        chk("wr0_busy", busy, 1);
        chk("wr0_not_yet", cp_key, 0);
        step();
        chk("wr0_key", cp_key, K);
        chk("wr0_no_tx", tx_send, 0);
        send(8'h51, 8'h51, P);
        step();
        chk("wr1_text", cp_text, P);
        chk("wr1_key_kept", cp_key, K);

        send(8'h41, 8'h41, PING);
        chk("ping_c1", tx_send, 0);
        step();
        chk("ping_c2", tx_send, 0);
        step();
        chk("ping_c3", tx_send, 1);
        chk("ping_frame", tx_frame, {8'h41, PING, 8'h41});
        step();
        chk("ping_c4", tx_send, 0);
        chk("ping_idle", busy, 0);

        tx_busy = 1'b1;
        send(8'h41, 8'h41, X);
        step();
        step();
        frame_data  = {8'h50, R3, 8'h50};
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            hits += int'(tx_send);
        end
        chk("busy_hold_no_tx", hits, 0);
        chk("drop_err", err_count, 1);
        tx_busy = 1'b0;
        chk("busy_fall_c0", tx_send, 0);
        step();
        chk("busy_fall_c1", tx_send, 1);
        chk("busy_frame", tx_frame, {8'h41, X, 8'h41});
        step();
        chk("busy_pulse_end", tx_send, 0);
        chk("drop_no_write", cp_key, K);

        send(8'h61, 8'h61, '0);
        step();
        step();
        chk("rd1_send", tx_send, 1);
        chk("rd1_frame", tx_frame, {8'h61, P, 8'h61});

        send(8'h42, 8'h42, '0);
        step();
        chk("b_noresult_err", err_count, 2);
        hits = int'(tx_send);
        step();
        hits += int'(tx_send);
        chk("b_noresult_no_tx", hits, 0);
        chk("b_noresult_idle", busy, 0);

        send(8'h45, 8'h45, '0);
        chk("e_ld", cp_ld, 1);
        hits = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            hits += int'(cp_ld);
        end
        chk("e_wait_busy", busy, 1);
        step();
        cp_done   = 1'b1;
        cp_result = R;
        step();
        cp_done = 1'b0;
        chk("e_ld_once", hits, 1);
        chk("e_done_idle", busy, 0);
        chk("e_result_valid", result_valid, 1);
        send(8'h42, 8'h42, '0);
        step();
        step();
        chk("b_send", tx_send, 1);
        chk("b_frame", tx_frame, {8'h42, R, 8'h42});
        chk("b_err_kept", err_count, 2);

        send(8'h45, 8'h45, '0);
        step();
        chk("to_rv_cleared", result_valid, 0);
        for (int i = 0; i < 15; i++)
            step();
        chk("to_busy_last", busy, 1);
        step();
        chk("to_idle", busy, 0);
        chk("to_err", err_count, 3);
        cp_done   = 1'b1;
        cp_result = R3;
        step();
        cp_done = 1'b0;
        chk("to_done_ignored", result_valid, 0);

        send(8'h45, 8'h45, '0);
        for (int i = 0; i < 16; i++)
            step();
        cp_done   = 1'b1;
        cp_result = R2;
        step();
        cp_done = 1'b0;
        chk("tie_idle", busy, 0);
        chk("tie_rv", result_valid, 1);
        chk("tie_err", err_count, 3);
        send(8'h42, 8'h42, '0);
        step();
        step();
        chk("tie_frame", tx_frame, {8'h42, R2, 8'h42});

        send(8'h50, 8'h51, R3);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        chk("tag_plus_drop_err", err_count, 4);
        chk("tag_no_write", cp_key, K);
        send(8'h57, 8'h57, R3);
        step();
        chk("slot_range_err", err_count, 5);
        send(8'h64, 8'h64, '0);
        step();
        chk("rd_range_err", err_count, 6);
        chk("rd_range_no_tx", tx_send, 0);

        for (int i = 0; i < 200; i++) begin
            send(8'h33, 8'h34, '0);
            step();
        end
        chk("err_206", err_count, 206);
        for (int i = 0; i < 100; i++) begin
            send(8'h33, 8'h34, '0);
            step();
        end
        chk("err_sat", err_count, 255);

        send(8'h45, 8'h45, '0);
        step();
        step();
        chk("rst_mid_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_err", err_count, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_key", cp_key, 0);
        chk("rst2_text", cp_text, 0);
        chk("rst2_frame", tx_frame, 0);
        chk("rst2_rv", result_valid, 0);
        chk("rst2_ld", cp_ld, 0);
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            hits += int'(tx_send) + int'(busy);
        end
        chk("rst2_quiet", hits, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
